// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR owner with a req/ready instruction-memory handshake and stall generation
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_write,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  func3,
  output logic        func7,
  output logic        instr_valid,
  output logic        stall,
  output logic        fetch_err,
  output logic [1:0]  err_code
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_pc, r_old_pc, r_instr;
  logic            r_valid;
  logic [1:0]      r_err_code;
  logic            w_aligned, w_done, w_tmo;
  assign w_aligned   = r_pc[1:0] == 2'b00;
  assign w_done      = r_state == S_WAIT && mem_ready;
  assign w_tmo       = r_state == S_WAIT && !mem_ready && r_cnt == CW'(TIMEOUT - 1);
  assign pc          = r_pc;
  assign mem_addr    = r_pc;
  assign old_pc      = r_old_pc;
  assign instr       = r_instr;
  assign op          = r_instr[6:0];
  assign func3       = r_instr[14:12];
  assign func7       = r_instr[30];
  assign instr_valid = r_valid;
  assign fetch_err   = r_state == S_ERR;
  assign err_code    = r_err_code;
  // next state plus the combinational request and stall lines
  always_comb begin
    w_next  = r_state;
    mem_req = 1'b0;
    stall   = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_req = ir_write && w_aligned;
        stall   = ir_write;
        w_next  = !ir_write ? S_IDLE : w_aligned ? S_WAIT : S_ERR;
      end
      S_WAIT: begin
        mem_req = 1'b1;
        stall   = !mem_ready;
        w_next  = mem_ready ? S_IDLE : w_tmo ? S_ERR : S_WAIT;
      end
      default: begin
        stall  = 1'b1;
        w_next = S_ERR;
      end
    endcase
  end
  // state, PC, IR and error bookkeeping; PC and IR may update on the same completing edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_old_pc   <= '0;
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
      r_err_code <= 2'b00;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      if (pc_write && !stall) r_pc <= pc_next;
      if (r_state == S_IDLE && ir_write) begin
        if (w_aligned) begin
          r_valid <= 1'b0;
          r_cnt   <= '0;
        end else r_err_code <= 2'b10;
      end
      if (w_done) begin
        r_instr  <= mem_rdata;
        r_old_pc <= r_pc;
        r_valid  <= 1'b1;
      end
      if (r_state == S_WAIT && !mem_ready) begin
        if (w_tmo) r_err_code <= 2'b01;
        else r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus randomized fetches checked against a transaction-level model
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, ir_write, pc_write, mem_ready;
  logic [31:0] pc_next, mem_rdata;
  logic        mem_req, instr_valid, stall, fetch_err, func7;
  logic [31:0] mem_addr, pc, old_pc, instr;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic [1:0]  err_code;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [31:0] m_pc, m_old, m_instr;
  logic        m_valid;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .ir_write(ir_write), .pc_write(pc_write), .pc_next(pc_next),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
    .pc(pc), .old_pc(old_pc), .instr(instr), .op(op), .func3(func3), .func7(func7),
    .instr_valid(instr_valid), .stall(stall), .fetch_err(fetch_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".old_pc"}, old_pc, m_old);
    chk({tag, ".instr"}, instr, m_instr);
    chk({tag, ".op"}, {25'd0, op}, {25'd0, m_instr[6:0]});
    chk({tag, ".func3"}, {29'd0, func3}, {29'd0, m_instr[14:12]});
    chk({tag, ".func7"}, {31'd0, func7}, {31'd0, m_instr[30]});
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, m_valid});
  endtask

  task automatic do_reset();
    rst = 1'b0; ir_write = 1'b0; pc_write = 1'b0; mem_ready = 1'b0;
    pc_next = '0; mem_rdata = '0;
    cyc();
    rst = 1'b1;
    m_pc = 32'h0; m_old = 32'h0; m_instr = 32'h0000_0013; m_valid = 1'b0;
  endtask

  // one fetch with a given number of wait states; PC-write request held throughout
  task automatic do_fetch(input string tag, input logic [31:0] data, input int waits,
                          input logic pw, input logic [31:0] nxt);
    logic [31:0] a;
    a = m_pc;
    ir_write = 1'b1; pc_write = pw; pc_next = nxt; mem_ready = 1'b0;
    #1;
    chk({tag, ".req0"}, {31'd0, mem_req}, 32'd1);
    chk({tag, ".stall0"}, {31'd0, stall}, 32'd1);
    cyc();
    ir_write = 1'b0;
    for (int i = 0; i < waits; i++) begin
      mem_rdata = $urandom;
      #1;
      chk({tag, ".wstall"}, {31'd0, stall}, 32'd1);
      chk({tag, ".waddr"}, mem_addr, a);
      chk({tag, ".wpc"}, pc, a);
      chk({tag, ".werr"}, {31'd0, fetch_err}, 32'd0);
      cyc();
    end
    mem_ready = 1'b1; mem_rdata = data;
    #1;
    chk({tag, ".dstall"}, {31'd0, stall}, 32'd0);
    chk({tag, ".dreq"}, {31'd0, mem_req}, 32'd1);
    chk({tag, ".daddr"}, mem_addr, a);
    cyc();
    mem_ready = 1'b0; pc_write = 1'b0;
    m_old = a; m_instr = data; m_valid = 1'b1;
    if (pw) m_pc = nxt;
    #1;
    chk({tag, ".req_after"}, {31'd0, mem_req}, 32'd0);
    chk({tag, ".stall_after"}, {31'd0, stall}, 32'd0);
    chk_arch(tag);
  endtask

  initial begin
    logic [31:0] d, nx;
    int w;
    logic pw;
    do_reset();
    chk("rst.req", {31'd0, mem_req}, 32'd0);
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.err", {31'd0, fetch_err}, 32'd0);
    chk("rst.code", {30'd0, err_code}, 32'd0);
    chk_arch("rst");

    do_fetch("t1", 32'h0050_0093, 0, 1'b1, 32'h4);
    chk("t1.op", {25'd0, op}, 32'h13);
    do_fetch("t2", 32'h0010_8113, 3, 1'b1, 32'h8);

    for (int k = 0; k < 10; k++) begin
      d  = $urandom;
      w  = $urandom_range(0, 6);
      pw = 1'($urandom_range(0, 1));
      nx = {$urandom, 2'b00};
      do_fetch("rnd", d, w, pw, nx);
    end

    mem_ready = 1'b1; mem_rdata = 32'hdead_beef;
    cyc();
    mem_ready = 1'b0;
    cyc();
    chk_arch("t6.idle_ready");
    do_fetch("t6", 32'h4000_0033, 1, 1'b0, 32'h0);
    chk("t6.func7", {31'd0, func7}, 32'd1);

    pc_write = 1'b1; pc_next = 32'h6;
    cyc();
    pc_write = 1'b0; m_pc = 32'h6;
    chk("t4.pc", pc, 32'h6);
    ir_write = 1'b1;
    #1;
    chk("t4.req", {31'd0, mem_req}, 32'd0);
    chk("t4.stall", {31'd0, stall}, 32'd1);
    cyc();
    ir_write = 1'b0; pc_write = 1'b1; pc_next = 32'h100;
    #1;
    chk("t4.err", {31'd0, fetch_err}, 32'd1);
    chk("t4.code", {30'd0, err_code}, 32'h2);
    chk("t4.req_err", {31'd0, mem_req}, 32'd0);
    cyc();
    chk("t4.pc_frozen", pc, 32'h6);

    do_reset();
    ir_write = 1'b1;
    cyc();
    ir_write = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("t3.req", {31'd0, mem_req}, 32'd1);
      chk("t3.noerr", {31'd0, fetch_err}, 32'd0);
      cyc();
    end
    pc_write = 1'b1; pc_next = 32'h40; mem_ready = 1'b1;
    #1;
    chk("t3.err", {31'd0, fetch_err}, 32'd1);
    chk("t3.code", {30'd0, err_code}, 32'h1);
    chk("t3.req_err", {31'd0, mem_req}, 32'd0);
    chk("t3.stall", {31'd0, stall}, 32'd1);
    cyc();
    cyc();
    chk("t3.pc_frozen", pc, 32'h0);
    chk("t3.sticky", {31'd0, fetch_err}, 32'd1);
    chk("t3.instr", instr, 32'h0000_0013);

    do_reset();
    do_fetch("t5pre", 32'h00a0_0513, 0, 1'b1, 32'h10);
    ir_write = 1'b1;
    cyc();
    ir_write = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    m_pc = 32'h0; m_old = 32'h0; m_instr = 32'h0000_0013; m_valid = 1'b0;
    chk("t5.req", {31'd0, mem_req}, 32'd0);
    chk("t5.stall", {31'd0, stall}, 32'd0);
    chk_arch("t5");
    do_fetch("t5post", 32'h0000_0533, 2, 1'b1, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
